uart_rx: RTL and testbench

UART_RX -- requirements
Module: uartrx

---
 rtl/uart_rx.sv | 150 +++++++++++++++
 tb/tb_uart_rx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, a one-byte holding register and overrun detection.
// Define UARTRX_FRAMEERR_EN to check the stop bit and report framing errors on ferr.
module uart_rx #(
  parameter int PREDIV  = 833,
  parameter int PREBITS = 10
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       phyrx,
  input  logic       rxack,
  output logic [7:0] charout,
  output logic       rxvalid,
  output logic       overrun,
  output logic       ferr
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
  localparam logic [2:0] WAITHI = 3'd4;

  // The counter restarts at 0 one cycle after the start edge, so a sample that
  // falls PREDIV/2 cycles after the edge is seen when the count reads PREDIV/2-1.
  localparam logic [PREBITS-1:0] PRE_MAX = PREBITS'(PREDIV);
  localparam logic [PREBITS-1:0] PRE_MID = PREBITS'(PREDIV / 2 - 1);

  logic               rx_m;
  logic               rx_s;
  logic               rx_d;
  logic [2:0]         state;
  logic [PREBITS-1:0] pre_cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shreg;

  logic start_edge;
  logic mid_tick;
  logic stop_tick;
  logic deliver;
  logic frame_bad;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; a blocking chain here would collapse the synchronizer.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= phyrx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign start_edge = rx_d & ~rx_s;
  assign mid_tick   = (pre_cnt == PRE_MID);
  assign stop_tick  = (state == STOP) && mid_tick;

`ifdef UARTRX_FRAMEERR_EN
  assign frame_bad = stop_tick & ~rx_s;
  assign deliver   = stop_tick & rx_s;
`else
  assign frame_bad = 1'b0;
  assign deliver   = stop_tick;
`endif

  // Bit-period counter: held at zero while idle, free-running modulo PREDIV+1 otherwise.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      pre_cnt <= '0;
    end else if (state == IDLE) begin
      pre_cnt <= '0;
    end else if (pre_cnt == PRE_MAX) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state   <= IDLE;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (start_edge) state <= START;
        end
        START: begin
          if (mid_tick) begin
            bit_idx <= 3'd0;
            state   <= rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (mid_tick) begin
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (mid_tick) state <= frame_bad ? WAITHI : IDLE;
        end
        WAITHI: begin
          // Wait for the line to return high so a stuck-low line cannot retrigger.
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Holding register: a delivery that coincides with an acknowledge replaces the
  // held byte; a delivery into an unacknowledged byte is dropped and flagged.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      charout <= 8'h00;
      rxvalid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (deliver) begin
        if (!rxvalid || rxack) begin
          charout <= shreg;
          rxvalid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rxvalid && rxack) begin
        rxvalid <= 1'b0;
      end
    end
  end

`ifdef UARTRX_FRAMEERR_EN
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      ferr <= 1'b0;
    end else begin
      ferr <= frame_bad;
    end
  end
`else
  assign ferr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are queued when driven and matched,
// with exact latency, whenever the receiver loads a new byte.
module tb_uart_rx;

  localparam int PREDIV  = 199;
  localparam int PREBITS = 8;
  localparam int BIT     = PREDIV + 1;
  localparam int HALF    = PREDIV / 2;
  // 2 synchronizer cycles + edge-detect cycle + mid-bit offset + 9 bit periods
  localparam int LAT     = 3 + HALF + 9 * BIT;

  logic       clk;
  logic       n_rst;
  logic       phyrx;
  logic       rxack;
  logic [7:0] charout;
  logic       rxvalid;
  logic       overrun;
  logic       ferr;

  uart_rx #(.PREDIV(PREDIV), .PREBITS(PREBITS)) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .phyrx   (phyrx),
    .rxack   (rxack),
    .charout (charout),
    .rxvalid (rxvalid),
    .overrun (overrun),
    .ferr    (ferr)
  );

  typedef struct {
    logic [7:0] data;
    int         t0;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_bad    = 0;
  int   cyc      = 0;
  int   n_ovr    = 0;
  int   n_ferr   = 0;
  int   n_deliv  = 0;
  int   n_push   = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_char  = 8'h00;
  event frame_started;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: a load is a rising rxvalid or a new byte replacing a held one.
  always @(negedge clk) begin
    if (n_rst) begin
      if (overrun) n_ovr++;
      if (ferr) n_ferr++;
      if (rxvalid && (!prev_valid || charout != prev_char)) begin
        n_deliv++;
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("data", {24'h0, charout}, {24'h0, e.data});
          check("latency", cyc - e.t0, LAT);
        end
      end
      prev_valid = rxvalid;
      prev_char  = charout;
    end else begin
      prev_valid = 1'b0;
      prev_char  = 8'h00;
    end
  end

  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic expect_deliv);
    exp_t e;
    @(posedge clk);
    #1 phyrx = 1'b0;
    if (expect_deliv) begin
      e.data = data;
      e.t0   = cyc;
      sb.push_back(e);
      n_push++;
    end
    -> frame_started;
    for (int i = 0; i < 8; i++) begin
      repeat (BIT) @(posedge clk);
      #1 phyrx = data[i];
    end
    repeat (BIT) @(posedge clk);
    #1 phyrx = stop_bit;
    repeat (BIT) @(posedge clk);
    #1 phyrx = 1'b1;
  endtask

  task automatic ack_pulse();
    @(posedge clk);
    #1 rxack = 1'b1;
    @(posedge clk);
    #1 rxack = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_rst = 1'b0;
    phyrx = 1'b1;
    rxack = 1'b0;
    repeat (4) @(posedge clk);
    #1 n_rst = 1'b1;
    @(negedge clk);
    check("rst_rxvalid", {31'h0, rxvalid}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);
    check("rst_ferr", {31'h0, ferr}, 32'h0);
    check("rst_charout", {24'h0, charout}, 32'h0);

    // Basic frame, then acknowledge
    send_frame(8'h55, 1'b1, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("f55_valid", {31'h0, rxvalid}, 32'h1);
    check("f55_char", {24'h0, charout}, 32'h55);
    ack_pulse();
    @(negedge clk);
    check("f55_acked", {31'h0, rxvalid}, 32'h0);

    // Short low glitch must be rejected as a false start
    @(posedge clk);
    #1 phyrx = 1'b0;
    repeat (60) @(posedge clk);
    #1 phyrx = 1'b1;
    repeat (2 * BIT) @(posedge clk);
    @(negedge clk);
    check("glitch_valid", {31'h0, rxvalid}, 32'h0);
    check("glitch_ovr", n_ovr, 0);
    check("glitch_ferr", n_ferr, 0);
    send_frame(8'h3C, 1'b1, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("f3c_char", {24'h0, charout}, 32'h3C);
    ack_pulse();

    // Overrun: second byte dropped while first is unacknowledged
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("ovr_count", n_ovr, 1);
    check("ovr_char", {24'h0, charout}, 32'h11);
    check("ovr_valid", {31'h0, rxvalid}, 32'h1);
    ack_pulse();
    @(negedge clk);
    check("ovr_acked", {31'h0, rxvalid}, 32'h0);

    // Acknowledge coinciding with the delivery cycle replaces the held byte
    send_frame(8'h11, 1'b1, 1'b1);
    fork
      send_frame(8'h22, 1'b1, 1'b1);
      begin
        @(frame_started);
        repeat (2 + HALF + 9 * BIT) @(posedge clk);
        #1 rxack = 1'b1;
        @(posedge clk);
        #1 rxack = 1'b0;
      end
    join
    @(negedge clk);
    check("same_valid", {31'h0, rxvalid}, 32'h1);
    check("same_char", {24'h0, charout}, 32'h22);
    check("same_ovr", n_ovr, 1);
    ack_pulse();

    // Stop bit sampled low
    send_frame(8'hA3, 1'b0, 1'b0
`ifndef UARTRX_FRAMEERR_EN
      | 1'b1
`endif
    );
    repeat (5) @(posedge clk);
    @(negedge clk);
`ifdef UARTRX_FRAMEERR_EN
    check("ferr_count", n_ferr, 1);
    check("ferr_valid", {31'h0, rxvalid}, 32'h0);
`else
    check("ferr_count", n_ferr, 0);
    check("ferr_char", {24'h0, charout}, 32'hA3);
    check("ferr_valid", {31'h0, rxvalid}, 32'h1);
    ack_pulse();
`endif

    // Reset during data bit 4 abandons the frame
    fork
      send_frame(8'hF0, 1'b1, 1'b0);
      begin
        @(frame_started);
        repeat (HALF + 5 * BIT) @(posedge clk);
        #1 n_rst = 1'b0;
        repeat (4) @(posedge clk);
        #1 n_rst = 1'b1;
      end
    join
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("midrst_valid", {31'h0, rxvalid}, 32'h0);
    check("midrst_char", {24'h0, charout}, 32'h0);
    send_frame(8'h0F, 1'b1, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("f0f_char", {24'h0, charout}, 32'h0F);
    check("f0f_valid", {31'h0, rxvalid}, 32'h1);
    ack_pulse();

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("deliveries", n_deliv, n_push);
    check("sb_left", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
